// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the single-bus datapath sequencer: opcodes, enable
// and bus-driver bit positions, FSM states and instruction field helpers.
package seq_pkg;

  localparam int INSTR_W = 10;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_MOV = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;

  // en_reg bit positions above the eight general registers
  localparam int EN_A = 11;
  localparam int EN_G = 10;
  localparam int EN_B = 9;
  localparam int EN_H = 8;

  // tri_reg bit positions above the eight general registers
  localparam int TRI_IMM  = 8;
  localparam int TRI_HOUT = 9;
  localparam int TRI_GOUT = 10;

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} seq_state_e;

  typedef enum logic [2:0] {C_NOP, C_LDI, C_MOV, C_ADD, C_XOR, C_ILL} op_class_e;

  function automatic logic [3:0] instr_op(input logic [INSTR_W-1:0] i);
    return i[9:6];
  endfunction

  function automatic logic [2:0] instr_rx(input logic [INSTR_W-1:0] i);
    return i[5:3];
  endfunction

  function automatic logic [2:0] instr_ry(input logic [INSTR_W-1:0] i);
    return i[2:0];
  endfunction

  function automatic logic [7:0] reg_onehot(input logic [2:0] r);
    return 8'd1 << r;
  endfunction

endpackage

// File: rtl/datapath_sequencer_op_decoder.sv
// Combinational opcode classifier: op class plus number of micro-steps.
module op_decoder
  import seq_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_e  op_cls,
  output logic [1:0] steps
);

  always_comb begin
    op_cls = C_ILL;
    steps  = 2'd1;
    case (opcode)
      OP_NOP: op_cls = C_NOP;
      OP_LDI: op_cls = C_LDI;
      OP_MOV: op_cls = C_MOV;
      OP_ADD: begin op_cls = C_ADD; steps = 2'd3; end
      OP_XOR: begin op_cls = C_XOR; steps = 2'd3; end
      default: op_cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle micro-sequencer driving one-hot load enables and bus drivers
// for the single-bus CPU datapath; at most one bus driver per cycle.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ARG_NUM  = 2,
  parameter int NUM_REGS = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 instr_valid,
  input  logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0]  instruction,
  output logic                                 instr_ready,
  output logic [NUM_REGS+3:0]                  en_reg,
  output logic [NUM_REGS+2:0]                  tri_reg,
  output logic                                 done,
  output logic                                 addclr,
  output logic                                 xorclr,
  output logic                                 illegal,
  output seq_state_e                           state_dbg
);

  // Handshake: a word transfers on the rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE, and memory
  // holds the word until then. Valid outside IDLE is ignored.

  seq_state_e         state;
  logic [INSTR_W-1:0] instr_q;
  op_class_e          op_cls;
  logic [1:0]         steps;
  logic [7:0]         rx_oh;
  logic [7:0]         ry_oh;

  op_decoder u_op_decoder (
    .opcode (instr_op(instr_q)),
    .op_cls (op_cls),
    .steps  (steps)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      instr_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (instr_valid) begin
          instr_q <= instruction;
          state   <= S_T1;
        end
        S_T1:    state <= (steps == 2'd1) ? S_IDLE : S_T2;
        S_T2:    state <= S_T3;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;
  assign rx_oh     = reg_onehot(instr_rx(instr_q));
  assign ry_oh     = reg_onehot(instr_ry(instr_q));

  // Decoded only from the state register and latched word, so an async reset
  // drops every enable immediately.
  always_comb begin
    instr_ready = (state == S_IDLE);
    en_reg      = '0;
    tri_reg     = '0;
    done        = 1'b0;
    addclr      = 1'b0;
    xorclr      = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_T1: case (op_cls)
        C_NOP: done = 1'b1;
        C_LDI: begin
          tri_reg[TRI_IMM]        = 1'b1;
          en_reg[NUM_REGS-1:0]    = rx_oh;
          done                    = 1'b1;
        end
        C_MOV: begin
          tri_reg[NUM_REGS-1:0]   = ry_oh;
          en_reg[NUM_REGS-1:0]    = rx_oh;
          done                    = 1'b1;
        end
        C_ADD: begin
          tri_reg[NUM_REGS-1:0]   = rx_oh;
          en_reg[EN_A]            = 1'b1;
        end
        C_XOR: begin
          tri_reg[NUM_REGS-1:0]   = rx_oh;
          en_reg[EN_B]            = 1'b1;
        end
        default: begin
          done    = 1'b1;
          illegal = 1'b1;
        end
      endcase
      S_T2: begin
        if (op_cls == C_ADD) begin
          tri_reg[NUM_REGS-1:0] = ry_oh;
          en_reg[EN_G]          = 1'b1;
        end else if (op_cls == C_XOR) begin
          tri_reg[NUM_REGS-1:0] = ry_oh;
          en_reg[EN_H]          = 1'b1;
        end
      end
      S_T3: begin
        if (op_cls == C_ADD) begin
          tri_reg[TRI_GOUT]     = 1'b1;
          en_reg[NUM_REGS-1:0]  = rx_oh;
          addclr                = 1'b1;
          done                  = 1'b1;
        end else if (op_cls == C_XOR) begin
          tri_reg[TRI_HOUT]     = 1'b1;
          en_reg[NUM_REGS-1:0]  = rx_oh;
          xorclr                = 1'b1;
          done                  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: per-cycle expected output
// vectors are queued when an instruction is offered and compared on negedges.
module tb_datapath_sequencer;
  import seq_pkg::*;

  localparam int W = 28;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [9:0]  instruction = '0;
  logic        instr_ready;
  logic [11:0] en_reg;
  logic [10:0] tri_reg;
  logic        done, addclr, xorclr, illegal;
  seq_state_e  state_dbg;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 clk = ~clk;

  datapath_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .instr_ready (instr_ready),
    .en_reg      (en_reg),
    .tri_reg     (tri_reg),
    .done        (done),
    .addclr      (addclr),
    .xorclr      (xorclr),
    .illegal     (illegal),
    .state_dbg   (state_dbg)
  );

  wire [W-1:0] obs = {instr_ready, done, addclr, xorclr, illegal, en_reg, tri_reg};

  // bus-contention invariant, every cycle
  always @(negedge clk) begin
    checks++;
    if ($countones(tri_reg) > 1) begin
      errors++;
      $display("FAIL tri_onehot: tri_reg=%h has more than one driver", tri_reg);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack(input logic rdy, input logic dn, input logic ac,
                                        input logic xc, input logic il,
                                        input logic [11:0] en, input logic [10:0] tr);
    return {rdy, dn, ac, xc, il, en, tr};
  endfunction

  function automatic logic [W-1:0] idle_vec();
    return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 11'h000);
  endfunction

  // reference model: expected outputs for the offering IDLE cycle and each step
  task automatic push_model(input logic [9:0] ins);
    logic [11:0] en_rx;
    logic [10:0] tri_rx, tri_ry;
    en_rx  = 12'd1 << ins[5:3];
    tri_rx = 11'd1 << ins[5:3];
    tri_ry = 11'd1 << ins[2:0];
    exp_q.push_back(idle_vec());
    case (ins[9:6])
      4'b0000: exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 11'h000));
      4'b0001: exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, en_rx, 11'h100));
      4'b0010: exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, en_rx, tri_ry));
      4'b0011: begin
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h800, tri_rx));
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h400, tri_ry));
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, en_rx, 11'h400));
      end
      4'b0100: begin
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h200, tri_rx));
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100, tri_ry));
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, en_rx, 11'h200));
      end
      default: exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 11'h000));
    endcase
  endtask

  // driver: called just after a rising edge while the DUT is idle
  task automatic send(input logic [9:0] ins);
    instr_valid = 1'b1;
    instruction = ins;
    push_model(ins);
  endtask

  task automatic test_reset();
    logic [W-1:0] exp;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== idle_vec() || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_hold: got %h state %0d want %h state 0", obs, state_dbg, idle_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    repeat (2) exp_q.push_back(idle_vec());
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_idle: got %h want %h", obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ldi();
    logic [W-1:0] exp;
    send(10'b0001_011_000);
    exp_q.push_back(idle_vec());
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ldi: got %h want %h", obs, exp);
      end
      @(posedge clk); #1; instr_valid = 1'b0;
    end
  endtask

  task automatic test_add();
    logic [W-1:0] exp;
    send(10'b0011_001_010);
    exp_q.push_back(idle_vec());
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL add: got %h want %h", obs, exp);
      end
      @(posedge clk); #1; instr_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    send(10'b0100_101_101);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_xor: got %h want %h", obs, exp);
      end
      @(posedge clk); #1; instr_valid = 1'b0;
    end
    send(10'b0010_000_101);
    exp_q.push_back(idle_vec());
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_mov: got %h want %h", obs, exp);
      end
      @(posedge clk); #1; instr_valid = 1'b0;
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] exp;
    send(10'b1111_010_001);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL illegal: got %h want %h", obs, exp);
      end
      @(posedge clk); #1; instr_valid = 1'b0;
    end
    send(10'b0000_000_000);
    exp_q.push_back(idle_vec());
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL nop_after_illegal: got %h want %h", obs, exp);
      end
      @(posedge clk); #1; instr_valid = 1'b0;
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] exp;
    int i;
    send(10'b0011_011_100);
    exp_q.push_back(idle_vec());
    exp_q.push_back(idle_vec());
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL busy_ignore: got %h want %h", obs, exp);
      end
      @(posedge clk); #1;
      // offer an LDI R7 while the ADD is in T1/T2; it must be ignored
      instr_valid = (i < 2);
      instruction = 10'b0001_111_000;
      i++;
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_add();
    logic [W-1:0] exp;
    send(10'b0011_001_010);
    repeat (3) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rst_mid_pre: got %h want %h", obs, exp);
      end
      if (exp_q.size() > 1) begin
        @(posedge clk); #1; instr_valid = 1'b0;
      end
    end
    // now in the negedge half of T2
    #1 rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (obs !== idle_vec() || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL rst_mid_async: got %h state %0d want %h state 0", obs, state_dbg, idle_vec());
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== idle_vec()) begin
      errors++;
      $display("FAIL rst_mid_nodone: got %h want %h", obs, idle_vec());
    end
    rst = 1'b1;
    send(10'b0001_110_000);
    exp_q.push_back(idle_vec());
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rst_mid_resume: got %h want %h", obs, exp);
      end
      @(posedge clk); #1; instr_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp;
    logic [9:0]   ins;
    repeat (30) begin
      ins = {4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      send(ins);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random ins=%b: got %h want %h", ins, obs, exp);
        end
        @(posedge clk); #1; instr_valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add();
    test_back_to_back();
    test_illegal();
    test_busy_ignore();
    test_reset_mid_add();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle micro-sequencer for the single-bus CPU datapath: eight general registers, the A/G add path and the B/H xor path, all sharing one 16-bit tri-state bus. It accepts one 10-bit instruction at a time from instruction memory over a valid/ready handshake. It then drives the one-hot register-load and bus-drive enables, cycle by cycle, and pulses `done` on the final micro-step so memory advances. Its job is to guarantee that at most one source ever drives the bus.

## Interface
- `OP_SIZE`, 4, opcode width
- `ARG_SIZE`, 3, register-index width
- `ARG_NUM`, 2, operands per instruction
- `NUM_REGS`, 8, general registers (must equal 2**ARG_SIZE)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `instr_valid`  in  1  instruction word present
- `instruction`  in  OP_SIZE+ARG_NUM*ARG_SIZE (10)  [9:6] opcode, [5:3] Rx, [2:0] Ry
- `instr_ready`  out  1  sequencer idle, will accept
- `en_reg`  out  12  load enables: [7:0] R0-R7, [8] H, [9] B, [10] G, [11] A
- `tri_reg`  out  11  bus drivers: [7:0] R0-R7, [8] immediate data, [9] H, [10] G
- `done`  out  1  one-cycle pulse on last micro-step
- `addclr`  out  1  clear A after ADD write-back
- `xorclr`  out  1  clear B after XOR write-back
- `illegal`  out  1  one-cycle pulse, undefined opcode

## Operation
- States: IDLE, T1, T2, T3.
- IDLE: `instr_ready`=1; on `instr_valid` latch the instruction and go to T1. No enables are driven in IDLE.
- All outputs decode only from the registered state and the latched instruction, never from the `instruction` input.
- Opcodes and micro-steps:
  - 0000 NOP: T1 asserts `done` only.
  - 0001 LDI Rx: T1 asserts `tri_reg[8]`, `en_reg[Rx]`, `done`.
  - 0010 MOV Rx,Ry: T1 asserts `tri_reg[Ry]`, `en_reg[Rx]`, `done`. Rx==Ry is legal and harmless.
  - 0011 ADD Rx,Ry:
    - T1: `tri_reg[Rx]`, `en_reg[11]`.
    - T2: `tri_reg[Ry]`, `en_reg[10]`.
    - T3: `tri_reg[10]`, `en_reg[Rx]`, `addclr`, `done`.
  - 0100 XOR Rx,Ry:
    - T1: `tri_reg[Rx]`, `en_reg[9]`.
    - T2: `tri_reg[Ry]`, `en_reg[8]`.
    - T3: `tri_reg[9]`, `en_reg[Rx]`, `xorclr`, `done`.
  - 0101-1111: T1 asserts `done` and `illegal`. No enables.
- After the step that asserts `done`, the next state is IDLE.
- Invariant: `$countones(tri_reg)` ≤ 1 every cycle.
- Invariant: `en_reg` never loads the register that is driving the bus, except MOV Rx==Rx.
- `instr_valid` while not in IDLE is ignored. The word must be held by memory until accepted.

## Timing
- Reset (`rst`=0): state IDLE immediately, without waiting for a clock edge.
  - Output values: `instr_ready`=1; `en_reg`, `tri_reg`, `done`, `addclr`, `xorclr`, `illegal` all 0.
- Reset mid-instruction aborts the instruction. No `done` is produced and all enables drop asynchronously.
- Acceptance is on the rising edge where IDLE && `instr_valid`.
- Latency from accept edge to `done` cycle:
  - 1 cycle for NOP, LDI, MOV and illegal opcodes.
  - 3 cycles for ADD and XOR.
- Back-to-back throughput: one instruction per (steps+1) cycles, because IDLE always costs one cycle.
- `done`, `addclr`, `xorclr` and `illegal` are high exactly one cycle.

## Structure
- Shared package `seq_pkg` holds:
  - opcode constants;
  - en_reg/tri_reg index constants (A=11, G=10, B=9, H=8, IMM=8, GOUT=10, HOUT=9);
  - the state enum;
  - the instruction field slices.
- The natural sub-module is `op_decoder`. It is purely combinational and maps the latched opcode to an op class (NOP/LDI/MOV/ADD/XOR/ILL) and a step count.
- The top level holds the state register, the latched instruction and the output decode.

## Test plan
- Reset, then release with idle input → all enables 0, `instr_ready`=1, no pulses.
- LDI R3 (0001_011_000) → one cycle later `tri_reg`=0x100, `en_reg`=0x008, `done`=1; then IDLE.
- ADD R1,R2 (0011_001_010) → T1: tri 0x002 / en 0x800; T2: tri 0x004 / en 0x400; T3: tri 0x400 / en 0x002 / `addclr`=1 / `done`=1.
- XOR R5,R5 followed back-to-back by MOV R0,R5 → XOR sequence with `xorclr`, one IDLE cycle, then tri 0x020 / en 0x001.
- Opcode 1111 → `illegal`=1 and `done`=1 for one cycle, `en_reg`/`tri_reg` stay 0.
- Assert `rst` during ADD T2 → outputs drop to 0 before the next edge, no `done`; a new instruction after release runs normally.
- All tests: assertion `$countones(tri_reg)`≤1 checked every cycle.
